// File: rtl/shift_feeder.sv
// shift_feeder: serializes 4-bit words into a 4-bit left/right shifter, one bit per sh_load cycle.
// Define SHIFT_FEEDER_FIFO_EN to place a 2-entry FIFO ahead of the active word register.
module shift_feeder #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_word,
  input  logic       in_dir,
  output logic       sh_load,
  output logic       sh_data,
  output logic       sh_direction,
  output logic       word_done,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, PAUSE} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  state_t state;
  logic [1:0] cnt;
  logic [3:0] gcnt, word;
  logic dir, acc, has_buf, start, go, last;
  logic [4:0] head;
  assign acc = in_valid && in_ready;
  assign last = state == SHIFT && cnt == 2'd3;
  // start marks every cycle in which a new word may begin shifting on the next edge
  assign start = state == IDLE || (last && GAP == 0) || (state == PAUSE && gcnt == GAP_LAST);
  assign go = start && (has_buf || acc);
`ifdef SHIFT_FEEDER_FIFO_EN
  logic [4:0] mem [2];
  logic rd, wr, push, pop;
  logic [1:0] count;
  assign has_buf = count != 2'd0;
  assign head = has_buf ? mem[rd] : {in_dir, in_word};
  assign in_ready = !reset && count != 2'd2;
  assign pop = go && has_buf;
  // an accepted word bypasses the FIFO when it starts immediately from an empty FIFO
  assign push = acc && !(go && !has_buf);
  always_ff @(posedge clk)
    if (reset) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= {in_dir, in_word};
        wr <= !wr;
      end
      if (pop) rd <= !rd;
      count <= count + 2'(push) - 2'(pop);
    end
`else
  assign has_buf = 1'b0;
  assign head = {in_dir, in_word};
  assign in_ready = !reset && state == IDLE;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= 2'd0;
      gcnt <= 4'd0;
      word <= 4'd0;
      dir <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= last;
      cnt <= state == SHIFT ? cnt + 2'd1 : 2'd0;
      gcnt <= state == PAUSE ? gcnt + 4'd1 : 4'd0;
      if (go) {dir, word} <= head;
      state <= start ? (go ? SHIFT : IDLE) : last ? PAUSE : state;
    end
  assign sh_load = state == SHIFT;
  assign sh_data = dir ? word[~cnt] : word[cnt];
  assign sh_direction = dir;
  assign busy = state != IDLE || has_buf;
endmodule

// File: tb/tb_shift_feeder.sv
// tb_shift_feeder: drives GAP=0 and GAP=2 feeders and checks them against a word-schedule model.
module tb_shift_feeder;
`ifdef SHIFT_FEEDER_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic [1:0] in_valid = '0, in_dir = '0, in_ready, sh_load, sh_data, sh_direction, word_done, busy;
  logic [3:0] in_word [2] = '{4'd0, 4'd0};
  logic [3:0] sh_out [2] = '{4'd0, 4'd0};
  shift_feeder #(.GAP(0)) u0 (.clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_word(in_word[0]), .in_dir(in_dir[0]), .sh_load(sh_load[0]), .sh_data(sh_data[0]),
    .sh_direction(sh_direction[0]), .word_done(word_done[0]), .busy(busy[0]));
  shift_feeder #(.GAP(2)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_word(in_word[1]), .in_dir(in_dir[1]), .sh_load(sh_load[1]), .sh_data(sh_data[1]),
    .sh_direction(sh_direction[1]), .word_done(word_done[1]), .busy(busy[1]));
  // the downstream shifter, per its contract
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (sh_load[k]) sh_out[k] <= sh_direction[k] ? {sh_out[k][2:0], sh_data[k]} : {sh_data[k], sh_out[k][3:1]};
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // model: every accepted word gets a start cycle; everything else follows from start cycles
  int st [2][4096];
  logic [3:0] ww [2][4096];
  logic wd [2][4096];
  int nw [2] = '{0, 0}, base [2] = '{0, 0};
  logic [4:0] src [2][4096];
  int sh [2] = '{0, 0}, stl [2] = '{0, 0};
  logic [1:0] en = 2'b11;
  bit run = 1'b0;
  int cyc = 0;
  int le, cnt, j, lo, g, s;
  logic el, ed, edone, edir, erdy;
  logic [3:0] eout;
  always @(negedge clk) begin
    if (run)
      for (int k = 0; k < 2; k++) begin
        g = k ? 2 : 0;
        le = nw[k] > base[k] ? st[k][nw[k]-1] + 4 + g : -1000;
        lo = nw[k] - 6 > base[k] ? nw[k] - 6 : base[k];
        cnt = 0; el = 0; ed = 0; edone = 0; edir = 0; eout = 0;
        for (int i = lo; i < nw[k]; i++) begin
          if (st[k][i] > cyc) cnt++;
          if (st[k][i] <= cyc) edir = wd[k][i];
          if (cyc >= st[k][i] && cyc < st[k][i] + 4) begin
            el = 1;
            j = cyc - st[k][i];
            ed = wd[k][i] ? ww[k][i][3-j] : ww[k][i][j];
          end
          if (st[k][i] + 4 == cyc) begin
            edone = 1;
            eout = ww[k][i];
          end
        end
        erdy = !reset && (FIFO ? cnt < 2 : cyc >= le);
        chk($sformatf("in_ready[%0d]@%0d", k, cyc), in_ready[k], erdy);
        chk($sformatf("sh_load[%0d]@%0d", k, cyc), sh_load[k], el);
        chk($sformatf("sh_direction[%0d]@%0d", k, cyc), sh_direction[k], edir);
        chk($sformatf("word_done[%0d]@%0d", k, cyc), word_done[k], edone);
        chk($sformatf("busy[%0d]@%0d", k, cyc), busy[k], cyc < le);
        if (el) chk($sformatf("sh_data[%0d]@%0d", k, cyc), sh_data[k], ed);
        if (edone) chk($sformatf("shifter_out[%0d]@%0d", k, cyc), sh_out[k], eout);
        if (in_valid[k] && erdy) begin
          s = cyc + 1 > le ? cyc + 1 : le;
          st[k][nw[k]] = s;
          ww[k][nw[k]] = in_word[k];
          wd[k][nw[k]] = in_dir[k];
          nw[k]++;
          sh[k]++;
        end
        if (reset) base[k] = nw[k];
      end
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = en[k] && sh[k] < stl[k];
      {in_dir[k], in_word[k]} = in_valid[k] ? src[k][sh[k]] : 5'($urandom);
    end
  endtask
  task automatic push(input int k, input logic [3:0] w, input logic d);
    src[k][stl[k]] = {d, w};
    stl[k]++;
  endtask
  task automatic push2(input logic [3:0] w, input logic d);
    push(0, w, d);
    push(1, w, d);
  endtask
  task automatic drain();
    for (int t = 0; t < 400 && !(sh[0] == stl[0] && sh[1] == stl[1]); t++) tick();
    chk("drain", sh[0] == stl[0] && sh[1] == stl[1], 1);
    repeat (12) tick();
  endtask
  initial begin
    repeat (3) tick();
    run = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    push2(4'b1011, 1'b0);
    drain();
    push2(4'b0110, 1'b1);
    drain();
    push2(4'hA, 1'b0);
    push2(4'h3, 1'b1);
    push2(4'hF, 1'b0);
    drain();
    push2(4'hC, 1'b1);
    push2(4'h5, 1'b0);
    drain();
    push2(4'h5, 1'b0);
    for (int t = 0; t < 20 && !sh_load[0]; t++) tick();
    chk("reset_test_started", sh_load[0], 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push2(4'h9, 1'b1);
    drain();
    for (int t = 0; t < 1500; t++) begin
      tick();
      reset = $urandom_range(0, 149) == 0;
      en = 2'($urandom_range(0, 3) != 0) | 2'(($urandom_range(0, 3) != 0) << 1);
      for (int k = 0; k < 2; k++)
        if (stl[k] - sh[k] < 3) push(k, 4'($urandom), 1'($urandom));
    end
    reset = 1'b0;
    en = 2'b11;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
